// File: rtl/om_renderer_if.sv
// Bus between the object-memory renderer, the video timing generator and the game logic.
interface om_renderer_if;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        de;
  logic        hsync_in;
  logic        vsync_in;
  logic [6:0]  address_read_om;
  logic [10:0] data_read_om;
  logic        next_screen;
  logic        new_state;
  logic [11:0] rgb;
  logic        de_out;
  logic        hsync;
  logic        vsync;
  logic [7:0]  miss_count;

  modport slave (
    input  hcount, vcount, de, hsync_in, vsync_in, data_read_om, new_state,
    output address_read_om, next_screen, rgb, de_out, hsync, vsync, miss_count
  );

  modport master (
    output hcount, vcount, de, hsync_in, vsync_in, data_read_om, new_state,
    input  address_read_om, next_screen, rgb, de_out, hsync, vsync, miss_count
  );
endinterface

// File: rtl/om_renderer.sv
// Renders a 10x10 tile grid from object memory with a 2-cycle pixel pipeline and a
// per-frame handshake to the game logic. Define OM_GRID_LINES_EN to overlay grid lines.
module om_renderer #(
  parameter int unsigned H_OFS = 80,
  parameter int unsigned TILE  = 48
) (
  input logic          clk,
  input logic          rst,
  om_renderer_if.slave bus
);
  localparam int unsigned GridPx = 10 * TILE;
  localparam int unsigned SprLo  = (TILE - 32) / 2;
  localparam logic signed [7:0] SprLoS = 8'(SprLo);
  localparam logic signed [7:0] SprHiS = 8'(SprLo + 31);
  localparam logic [6:0] AddrNone = 7'd120;
  localparam logic [5:0] TileLast = 6'(TILE - 1);

  // ---------------- cycle 0: tile/pixel counters and address ----------------
  logic [5:0] px_q, py_q, px_c, py_c;
  logic [3:0] col_q, row_q, col_c, row_c;
  logic [9:0] vprev_q;
  logic       in_grid;

  assign in_grid = (bus.vcount < 10'(GridPx)) &&
                   ({1'b0, bus.hcount} >= 11'(H_OFS)) &&
                   ({1'b0, bus.hcount} < 11'(H_OFS + GridPx));

  // Counters hold the previous pixel's position; the current one is derived from it.
  always_comb begin
    px_c  = px_q + 6'd1;
    col_c = col_q;
    if (bus.hcount == 10'(H_OFS)) begin
      px_c  = '0;
      col_c = '0;
    end else if (px_q == TileLast) begin
      px_c  = '0;
      col_c = col_q + 4'd1;
    end

    py_c  = py_q;
    row_c = row_q;
    if (bus.vcount == 10'd0) begin
      py_c  = '0;
      row_c = '0;
    end else if (bus.vcount != vprev_q) begin
      if (py_q == TileLast) begin
        py_c  = '0;
        row_c = row_q + 4'd1;
      end else begin
        py_c = py_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q    <= '0;
      py_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      vprev_q <= '0;
    end else begin
      px_q    <= px_c;
      py_q    <= py_c;
      col_q   <= col_c;
      row_q   <= row_c;
      vprev_q <= bus.vcount;
    end
  end

  assign bus.address_read_om = (rst || !in_grid) ? AddrNone
                                                 : 7'(row_c) * 7'd10 + 7'(col_c);

  // ---------------- cycle 1: memory word arrives ----------------
  logic [5:0] px_s1_q, py_s1_q;
  logic       grid_s1_q, de_s1_q, hs_s1_q, vs_s1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_s1_q   <= '0;
      py_s1_q   <= '0;
      grid_s1_q <= 1'b0;
      de_s1_q   <= 1'b0;
      hs_s1_q   <= 1'b0;
      vs_s1_q   <= 1'b0;
    end else begin
      px_s1_q   <= px_c;
      py_s1_q   <= py_c;
      grid_s1_q <= in_grid;
      de_s1_q   <= bus.de;
      hs_s1_q   <= bus.hsync_in;
      vs_s1_q   <= bus.vsync_in;
    end
  end

  logic [2:0]        cell_type;
  logic [5:0]        cell_ofs;
  logic [1:0]        cell_dir;
  logic signed [7:0] sx, sy;
  logic              spr_hit;
  logic [11:0]       bg, spr, pix, rgb_d;

  assign {cell_type, cell_ofs, cell_dir} = bus.data_read_om;

  always_comb begin
    sx = $signed({2'b00, px_s1_q});
    sy = $signed({2'b00, py_s1_q});
    // Shifting the sprite one way is the same as shifting the sample point the other way.
    unique case (cell_dir)
      2'b00:   sx = sx + $signed({2'b00, cell_ofs});
      2'b01:   sx = sx - $signed({2'b00, cell_ofs});
      2'b10:   sy = sy + $signed({2'b00, cell_ofs});
      default: sy = sy - $signed({2'b00, cell_ofs});
    endcase
    spr_hit = cell_type[2] && (sx >= SprLoS) && (sx <= SprHiS) &&
              (sy >= SprLoS) && (sy <= SprHiS);

    bg = 12'h333;
    unique case (cell_type)
      3'd1, 3'd6, 3'd7: bg = 12'h0A0;
      3'd2:             bg = 12'h888;
      3'd3:             bg = 12'hFD0;
      default:          bg = 12'h333;
    endcase

    spr = ((cell_type == 3'd4) || (cell_type == 3'd7)) ? 12'hF80 : 12'hA52;
    pix = spr_hit ? spr : bg;
`ifdef OM_GRID_LINES_EN
    if ((px_s1_q == 6'd0) || (py_s1_q == 6'd0)) pix = 12'h111;
`endif
    rgb_d = (de_s1_q && grid_s1_q) ? pix : 12'h000;
  end

  // ---------------- cycle 2: registered outputs ----------------
  logic [11:0] rgb_q;
  logic        de_out_q, hsync_q, vsync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q    <= '0;
      de_out_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      de_out_q <= de_s1_q;
      hsync_q  <= hs_s1_q;
      vsync_q  <= vs_s1_q;
    end
  end

  assign bus.rgb    = rgb_q;
  assign bus.de_out = de_out_q;
  assign bus.hsync  = hsync_q;
  assign bus.vsync  = vsync_q;

  // ---------------- frame handshake ----------------
  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e     state_q, state_d;
  logic [2:0] hi_cnt_q, hi_cnt_d;
  logic       ack_q, ack_d;
  logic [7:0] miss_q, miss_d;
  logic       frame_req, frame_wrap, min_done;

  assign frame_req  = (bus.vcount == 10'd480) && (bus.hcount == 10'd0);
  assign frame_wrap = (bus.vcount == 10'd0) && (bus.hcount == 10'd0);
  assign min_done   = (hi_cnt_q == 3'd7);

  always_comb begin
    state_d  = state_q;
    hi_cnt_d = hi_cnt_q;
    ack_d    = ack_q;
    miss_d   = miss_q;
    unique case (state_q)
      StIdle: begin
        hi_cnt_d = '0;
        ack_d    = 1'b0;
        if (frame_req) begin
          state_d = StReq;
          ack_d   = bus.new_state;
        end
      end
      StReq: begin
        if (!min_done) hi_cnt_d = hi_cnt_q + 3'd1;
        ack_d = ack_q | bus.new_state;
        if (min_done && ack_d) begin
          state_d = StIdle;
        end else if (frame_wrap && !ack_d) begin
          state_d = StHold;
          if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
        end
      end
      StHold: begin
        if (!min_done) hi_cnt_d = hi_cnt_q + 3'd1;
        else           state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      hi_cnt_q <= '0;
      ack_q    <= 1'b0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      hi_cnt_q <= hi_cnt_d;
      ack_q    <= ack_d;
      miss_q   <= miss_d;
    end
  end

  assign bus.next_screen = (state_q != StIdle);
  assign bus.miss_count  = miss_q;
endmodule

// File: tb/tb_om_renderer.sv
// Directed bench for om_renderer: pixel pipeline colours, sync delay and frame handshake.
module tb_om_renderer;
`ifdef OM_GRID_LINES_EN
  localparam bit GridLines = 1'b1;
`else
  localparam bit GridLines = 1'b0;
`endif
  localparam int HOfs = 80;
  localparam int Tile = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  om_renderer_if bus ();

  om_renderer #(.H_OFS(HOfs), .TILE(Tile)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [10:0] om_mem [0:127];
  always @(posedge clk) bus.data_read_om <= om_mem[bus.address_read_om];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [31:0] v;
    logic [31:0] h;
    logic [11:0] rgb;
  } exp_t;

  localparam int NExp = 15;
  exp_t exps [NExp];

  function automatic logic [11:0] exp_rgb(input int v, input int h, input logic [11:0] c);
    if (GridLines && ((((h - HOfs) % Tile) == 0) || ((v % Tile) == 0))) return 12'h111;
    return c;
  endfunction

  // Scan line v from the top of the frame, then sweep hcount across the first cells.
  task automatic sweep(input int v);
    bus.de = 1'b0; bus.hcount = '0; bus.vcount = '0;
    tick();
    for (int y = 1; y <= v; y++) begin
      bus.vcount = 10'(y);
      tick();
    end
    bus.de = 1'b1;
    for (int h = HOfs; h <= 320; h++) begin
      bus.hcount = 10'(h);
      #1;
      if (v == 0 && h == HOfs) check("addr_cell0", 32'(bus.address_read_om), 32'd0);
      if (v == 116 && h == 254) check("addr_cell23", 32'(bus.address_read_om), 32'd23);
      tick();
      for (int i = 0; i < NExp; i++) begin
        if (int'(exps[i].v) == v && int'(exps[i].h) == h - 1)
          check($sformatf("rgb_v%0d_h%0d", v, h - 1), 32'(bus.rgb),
                32'(exp_rgb(v, h - 1, exps[i].rgb)));
      end
      if (v == 0 && h == HOfs + 2) check("de_out_active", 32'(bus.de_out), 32'd1);
    end
    bus.de = 1'b0;
  endtask

  task automatic trigger(input logic ack);
    bus.vcount = 10'd480; bus.hcount = '0; bus.new_state = ack;
    tick();
    bus.new_state = 1'b0; bus.hcount = 10'd1;
  endtask

  int hi;

  initial begin
    for (int i = 0; i < 128; i++) om_mem[i] = '0;
    om_mem[0]  = {3'd2, 8'd0};
    om_mem[1]  = {3'd1, 8'd0};
    om_mem[2]  = {3'd3, 8'd0};
    om_mem[3]  = {3'd5, 6'd0, 2'b00};
    om_mem[4]  = {3'd7, 6'd4, 2'b10};
    om_mem[22] = {3'd5, 6'd8, 2'b00};
    om_mem[23] = {3'd4, 6'd16, 2'b01};
    om_mem[24] = {3'd6, 6'd10, 2'b11};

    exps[0]  = '{32'd0,   32'd80,  12'h888};
    exps[1]  = '{32'd0,   32'd133, 12'h0A0};
    exps[2]  = '{32'd0,   32'd206, 12'hFD0};
    exps[3]  = '{32'd0,   32'd244, 12'h333};
    exps[4]  = '{32'd10,  32'd244, 12'hA52};
    exps[5]  = '{32'd10,  32'd264, 12'h333};
    exps[6]  = '{32'd10,  32'd292, 12'hF80};
    exps[7]  = '{32'd10,  32'd274, 12'h0A0};
    exps[8]  = '{32'd10,  32'd317, 12'h0A0};
    exps[9]  = '{32'd116, 32'd176, 12'hA52};
    exps[10] = '{32'd116, 32'd209, 12'h333};
    exps[11] = '{32'd116, 32'd254, 12'hF80};
    exps[12] = '{32'd116, 32'd232, 12'h333};
    exps[13] = '{32'd116, 32'd280, 12'hA52};
    exps[14] = '{32'd116, 32'd312, 12'h0A0};

    bus.hcount = 10'd100; bus.vcount = '0; bus.de = 1'b1;
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.new_state = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check("rst_addr", 32'(bus.address_read_om), 32'd120);
    check("rst_next_screen", 32'(bus.next_screen), 32'd0);
    check("rst_miss", 32'(bus.miss_count), 32'd0);
    check("rst_rgb", 32'(bus.rgb), 32'd0);
    check("rst_de_out", 32'(bus.de_out), 32'd0);
    bus.de = 1'b0; bus.hcount = '0;
    rst = 1'b0;
    tick();

    sweep(0);
    sweep(10);
    sweep(116);

    // de low inside the grid blanks the pixel
    bus.vcount = '0; bus.hcount = 10'(HOfs); bus.de = 1'b0;
    tick();
    bus.hcount = 10'(HOfs + 1);
    tick();
    check("rgb_de_low", 32'(bus.rgb), 32'd0);
    check("de_out_low", 32'(bus.de_out), 32'd0);

    // outside the grid: dummy address, black pixel
    bus.hcount = 10'd20; bus.de = 1'b1;
    #1 check("addr_outside", 32'(bus.address_read_om), 32'd120);
    tick(); tick();
    check("rgb_outside", 32'(bus.rgb), 32'd0);
    bus.de = 1'b0;

    // syncs delayed two cycles
    bus.hsync_in = 1'b1;
    tick();
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b1;
    check("hsync_d1", 32'(bus.hsync), 32'd0);
    tick();
    bus.vsync_in = 1'b0;
    check("hsync_d2", 32'(bus.hsync), 32'd1);
    check("vsync_d2", 32'(bus.vsync), 32'd0);
    tick();
    check("hsync_d3", 32'(bus.hsync), 32'd0);
    check("vsync_d3", 32'(bus.vsync), 32'd1);

    // acknowledge three cycles into the request
    trigger(1'b0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.next_screen) hi++;
      bus.new_state = (i == 2);
      tick();
      bus.hcount = bus.hcount + 10'd1;
    end
    bus.new_state = 1'b0;
    check("ns_len_ack", 32'(hi), 32'd8);
    check("miss_after_ack", 32'(bus.miss_count), 32'd0);

    // acknowledge coincident with the request start
    trigger(1'b1);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.next_screen) hi++;
      tick();
    end
    check("ns_len_ack_entry", 32'(hi), 32'd8);

    // new_state in IDLE ignored: full frame without acknowledge
    bus.vcount = 10'd300; bus.hcount = 10'd5; bus.new_state = 1'b1;
    tick();
    bus.new_state = 1'b0;
    trigger(1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("ns_held_no_ack", 32'(bus.next_screen), 32'd1);
    bus.vcount = '0; bus.hcount = '0;
    tick();
    bus.hcount = 10'd1; bus.new_state = 1'b1;
    check("ns_in_hold", 32'(bus.next_screen), 32'd1);
    tick();
    bus.new_state = 1'b0;
    check("ns_after_hold", 32'(bus.next_screen), 32'd0);
    check("miss_one", 32'(bus.miss_count), 32'd1);

    // 299 more quick misses: minimum high time kept, count saturates
    for (int k = 0; k < 299; k++) begin
      trigger(1'b0);
      hi = bus.next_screen ? 1 : 0;
      bus.vcount = '0; bus.hcount = '0;
      tick();
      if (bus.next_screen) hi++;
      bus.vcount = 10'd5; bus.hcount = 10'd7;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus.next_screen) hi++;
      end
      if (k == 0) check("ns_len_miss", 32'(hi), 32'd8);
      if (k == 0) check("miss_two", 32'(bus.miss_count), 32'd2);
    end
    check("miss_sat", 32'(bus.miss_count), 32'd255);

    // reset during a request
    trigger(1'b0);
    check("ns_before_rst", 32'(bus.next_screen), 32'd1);
    bus.hcount = 10'd20; bus.de = 1'b1;
    rst = 1'b1;
    #1;
    check("ns_async_rst", 32'(bus.next_screen), 32'd0);
    check("addr_in_rst", 32'(bus.address_read_om), 32'd120);
    check("rgb_in_rst", 32'(bus.rgb), 32'd0);
    check("miss_in_rst", 32'(bus.miss_count), 32'd0);
    tick(); tick();
    rst = 1'b0;
    bus.vcount = '0; bus.hcount = '0;
    tick();
    bus.vcount = 10'd479; bus.hcount = 10'd3;
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.next_screen) hi++;
    end
    check("ns_idle_after_rst", 32'(hi), 32'd0);
    check("rgb_after_rst", 32'(bus.rgb), 32'd0);
    trigger(1'b0);
    check("ns_first_req_after_rst", 32'(bus.next_screen), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
